tile_scheduler: RTL and testbench
=================================

TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 SHALL have parameter CH_W, default 11, meaning channel-count width (in_D, out_K).
REQ-002 SHALL have parameter DIM_W, default 8, meaning row, tile-size and out_R width.
REQ-003 SHALL have ports: clk  input  1  clock; rst  input  1  synchronous active-high reset.
REQ-004 SHALL have ports: start_i  input  1  one-cycle pulse to begin a layer; busy_o  output  1  layer in progress; done_o  output  1  one-cycle pulse after the last tile is accepted.
REQ-005 SHALL have config inputs, sampled only on accepted start_i: layer_type_i  2  (0=PW, 1=DW, 2=STD); in_D_i, out_K_i  CH_W; tile_D_i, tile_K_i  DIM_W; out_R_i  DIM_W; tile_n_i  32  output rows per tile.
REQ-006 SHALL have tile command outputs: tile_valid_o  1; tile_ready_i  input  1; row_base_o  DIM_W; row_len_o  DIM_W; k_base_o, d_base_o  CH_W; k_len_o, d_len_o  DIM_W; first_d_o  1  (initialise psum); last_d_o  1  (write back ofmap); tile_idx_o  32  running tile count.

Function
REQ-007 SHALL implement FSM IDLE -> SETUP -> ISSUE -> DONE -> IDLE.
REQ-008 IDLE: start_i=1 SHALL latch config and enter SETUP; start_i while busy_o=1 SHALL be ignored.
REQ-009 SETUP (1 cycle): rows_per_tile = 1 if tile_n=0, out_R if tile_n>out_R, else tile_n[DIM_W-1:0]; tile_D or tile_K of 0 SHALL be treated as 1; if in_D, out_K or out_R is 0, go to DONE without issuing.
REQ-010 Loop order SHALL be row tile (outer), K tile, D tile (inner); every counter resets to 0 when its enclosing counter advances.
REQ-011 row_len = min(rows_per_tile, out_R - row_base); k_len = min(tile_K, out_K - k_base); d_len = min(tile_D, in_D - d_base); all subtractions at CH_W+1 bits, no wrap.
REQ-012 For layer_type DW, the D loop SHALL collapse to one iteration with d_base = k_base, d_len = k_len, and first_d = last_d = 1.
REQ-013 first_d_o SHALL be 1 iff d_base=0; last_d_o SHALL be 1 iff d_base+d_len = in_D (DW: always 1).
REQ-014 ISSUE: tile_valid_o SHALL be 1; all command fields SHALL hold stable while tile_valid_o=1 and tile_ready_i=0.
REQ-015 A tile SHALL be accepted on a cycle with tile_valid_o=1 and tile_ready_i=1; the next tile SHALL be presented the following cycle (one tile per cycle at full throughput, no bubble).
REQ-016 tile_idx_o SHALL start at 0 per layer and increment by 1 per accepted tile.
REQ-017 Acceptance of the tile with last row, K and D SHALL move to DONE; DONE SHALL assert done_o for exactly one cycle and return to IDLE.
REQ-018 busy_o SHALL be 1 in SETUP, ISSUE and DONE, and 0 in IDLE.

Reset
REQ-019 rst=1 at a clock edge SHALL force IDLE and zero every output and counter, including mid-ISSUE with a tile pending; the pending tile SHALL be dropped.
REQ-020 After reset, no tile_valid_o SHALL assert before a new start_i.

Configuration
REQ-021 Macro TILE_SCHED_PERF_EN defined: add outputs stall_cnt_o (32, cycles in ISSUE with tile_ready_i=0) and layer_cyc_o (32, cycles from SETUP to DONE inclusive), both cleared on start_i and on reset, and held after done_o.
REQ-022 Without TILE_SCHED_PERF_EN the ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-023 Layer-type encodings (POINTWISE, DEPTHWISE, STANDARD) and the FSM state enum SHALL reside in the shared define package/header used by the controller.
REQ-024 A sub-module tile_len_calc (combinational min/clamp of base, tile size and total into a length) SHALL be instantiated three times: row, K and D.

Verification
REQ-025 PW, in_D=64, out_K=64, tile_D=tile_K=32, out_R=4, tile_n=2, ready always 1 -> 8 tiles on consecutive cycles; the first tile has first_d=1, last_d=0; the second has last_d=1; done_o fires 1 cycle after tile_idx=7.
REQ-026 STD, in_D=25, tile_D=10 -> d_len sequence 10, 10, 5; last_d only on the third.
REQ-027 DW, out_K=25, tile_K=10, out_R=3, tile_n=0 -> rows_per_tile=1; 9 tiles; each has d_base=k_base and first_d=last_d=1.
REQ-028 Random tile_ready_i stalls -> fields stable while stalled; 8 tiles total; with TILE_SCHED_PERF_EN, stall_cnt_o equals the number of stalled ISSUE cycles.
REQ-029 in_D=0 -> no tile_valid_o; done_o 2 cycles after start_i.
REQ-030 rst during the third tile of REQ-025 -> all outputs 0 next cycle; a new start_i reissues from tile_idx=0.

Source files
------------

// File: rtl/tile_scheduler_pkg.sv
// Shared definitions for the tile scheduler: layer-type encodings and the
// controller state enum.
package tile_scheduler_pkg;

  typedef enum logic [1:0] {
    LT_POINTWISE = 2'd0,
    LT_DEPTHWISE = 2'd1,
    LT_STANDARD  = 2'd2
  } layer_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/tile_scheduler_len_calc.sv
// tile_len_calc: length of one tile along one loop dimension,
// len = min(tile, total - base). The remainder is formed one bit wider than
// the base so it never wraps, and clamps to 0 when base has reached total.
module tile_len_calc #(
  parameter int BASE_W = 11,
  parameter int LEN_W  = 8
) (
  input  logic [BASE_W-1:0] base_i,
  input  logic [LEN_W-1:0]  tile_i,
  input  logic [BASE_W-1:0] total_i,
  output logic [LEN_W-1:0]  len_o
);

  localparam int W = (BASE_W + 1 > LEN_W) ? BASE_W + 1 : LEN_W;

  logic [W-1:0] remain;
  logic [W-1:0] tile_ext;

  // Clamp the tile size to whatever is left of the dimension.
  always_comb begin
    remain   = '0;
    tile_ext = W'(tile_i);
    if (total_i > base_i) remain = W'(total_i) - W'(base_i);
    len_o = (tile_ext < remain) ? tile_i : remain[LEN_W-1:0];
  end

endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks one layer as row tiles (outer), K tiles, D tiles
// (inner) and hands one tile command per accepted handshake to the engine.
// Optional feature macro: TILE_SCHED_PERF_EN adds stall_cnt_o / layer_cyc_o.
module tile_scheduler
  import tile_scheduler_pkg::*;
#(
  parameter int CH_W  = 11,
  parameter int DIM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic [1:0]       layer_type_i,
  input  logic [CH_W-1:0]  in_D_i,
  input  logic [CH_W-1:0]  out_K_i,
  input  logic [DIM_W-1:0] tile_D_i,
  input  logic [DIM_W-1:0] tile_K_i,
  input  logic [DIM_W-1:0] out_R_i,
  input  logic [31:0]      tile_n_i,
  output logic             tile_valid_o,
  input  logic             tile_ready_i,
  output logic [DIM_W-1:0] row_base_o,
  output logic [DIM_W-1:0] row_len_o,
  output logic [CH_W-1:0]  k_base_o,
  output logic [CH_W-1:0]  d_base_o,
  output logic [DIM_W-1:0] k_len_o,
  output logic [DIM_W-1:0] d_len_o,
  output logic             first_d_o,
  output logic             last_d_o,
`ifdef TILE_SCHED_PERF_EN
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      layer_cyc_o,
`endif
  output logic [31:0]      tile_idx_o
);

  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  state_e            state_q;
  logic              is_dw_q;
  logic [CH_W-1:0]   in_d_q, out_k_q;
  logic [DIM_W-1:0]  tile_d_q, tile_k_q, out_r_q, rpt_q;
  logic [31:0]       tile_n_q;
  logic [DIM_W-1:0]  row_q;
  logic [CH_W-1:0]   k_q, d_q;
  logic [31:0]       idx_q;

  logic [DIM_W-1:0]  row_len, k_len, d_len;
  logic [DIM_W:0]    row_nxt;
  logic [CH_W:0]     k_nxt, d_nxt;
  logic              row_wrap, k_wrap, d_wrap, issue;

  tile_len_calc #(.BASE_W(DIM_W), .LEN_W(DIM_W)) u_row_len (
    .base_i(row_q), .tile_i(rpt_q), .total_i(out_r_q), .len_o(row_len)
  );

  tile_len_calc #(.BASE_W(CH_W), .LEN_W(DIM_W)) u_k_len (
    .base_i(k_q), .tile_i(tile_k_q), .total_i(out_k_q), .len_o(k_len)
  );

  tile_len_calc #(.BASE_W(CH_W), .LEN_W(DIM_W)) u_d_len (
    .base_i(d_q), .tile_i(tile_d_q), .total_i(in_d_q), .len_o(d_len)
  );

  // Next loop positions and wrap conditions; depthwise never iterates D.
  always_comb begin
    row_nxt  = {1'b0, row_q} + (DIM_W+1)'(row_len);
    k_nxt    = {1'b0, k_q} + (CH_W+1)'(k_len);
    d_nxt    = {1'b0, d_q} + (CH_W+1)'(d_len);
    row_wrap = row_nxt >= {1'b0, out_r_q};
    k_wrap   = k_nxt >= {1'b0, out_k_q};
    d_wrap   = is_dw_q || (d_nxt >= {1'b0, in_d_q});
  end

  // Controller: config latch, loop counters and state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      is_dw_q  <= 1'b0;
      in_d_q   <= '0;
      out_k_q  <= '0;
      tile_d_q <= '0;
      tile_k_q <= '0;
      out_r_q  <= '0;
      tile_n_q <= '0;
      rpt_q    <= '0;
      row_q    <= '0;
      k_q      <= '0;
      d_q      <= '0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            is_dw_q  <= (layer_type_i == LT_DEPTHWISE);
            in_d_q   <= in_D_i;
            out_k_q  <= out_K_i;
            tile_d_q <= (tile_D_i == '0) ? DIM_ONE : tile_D_i;
            tile_k_q <= (tile_K_i == '0) ? DIM_ONE : tile_K_i;
            out_r_q  <= out_R_i;
            tile_n_q <= tile_n_i;
            row_q    <= '0;
            k_q      <= '0;
            d_q      <= '0;
            idx_q    <= '0;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tile_n_q == 32'd0)             rpt_q <= DIM_ONE;
          else if (tile_n_q > 32'(out_r_q))  rpt_q <= out_r_q;
          else                               rpt_q <= tile_n_q[DIM_W-1:0];
          if (in_d_q == '0 || out_k_q == '0 || out_r_q == '0) state_q <= ST_DONE;
          else                                                 state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (tile_ready_i) begin
            idx_q <= idx_q + 32'd1;
            if (!d_wrap) begin
              d_q <= d_nxt[CH_W-1:0];
            end else begin
              d_q <= '0;
              if (!k_wrap) begin
                k_q <= k_nxt[CH_W-1:0];
              end else begin
                k_q <= '0;
                if (!row_wrap) row_q   <= row_nxt[DIM_W-1:0];
                else           state_q <= ST_DONE;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Command fields are driven only while a tile is presented, zero otherwise.
  always_comb begin
    issue        = (state_q == ST_ISSUE);
    tile_valid_o = issue;
    busy_o       = (state_q != ST_IDLE);
    done_o       = (state_q == ST_DONE);
    tile_idx_o   = idx_q;
    row_base_o   = issue ? row_q : '0;
    row_len_o    = issue ? row_len : '0;
    k_base_o     = issue ? k_q : '0;
    k_len_o      = issue ? k_len : '0;
    d_base_o     = !issue ? '0 : (is_dw_q ? k_q : d_q);
    d_len_o      = !issue ? '0 : (is_dw_q ? k_len : d_len);
    first_d_o    = issue && (is_dw_q || d_q == '0);
    last_d_o     = issue && (is_dw_q || d_nxt == {1'b0, in_d_q});
  end

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, layer_cyc_q;

  // Layer statistics: cleared by an accepted start, frozen once back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      layer_cyc_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start_i) begin
        stall_cnt_q <= '0;
        layer_cyc_q <= '0;
      end
    end else begin
      layer_cyc_q <= layer_cyc_q + 32'd1;
      if (state_q == ST_ISSUE && !tile_ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign layer_cyc_o = layer_cyc_q;
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: the stimulus side pushes the expected
// tile sequence of each layer, a negedge monitor pops and compares on every
// accepted tile. Build with TILE_SCHED_PERF_EN to also check the counters.
module tb_tile_scheduler;

  localparam int CH_W  = 11;
  localparam int DIM_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             busy_o, done_o;
  logic [1:0]       layer_type_i = '0;
  logic [CH_W-1:0]  in_D_i = '0, out_K_i = '0;
  logic [DIM_W-1:0] tile_D_i = '0, tile_K_i = '0, out_R_i = '0;
  logic [31:0]      tile_n_i = '0;
  logic             tile_valid_o;
  logic             tile_ready_i = 1'b1;
  logic [DIM_W-1:0] row_base_o, row_len_o, k_len_o, d_len_o;
  logic [CH_W-1:0]  k_base_o, d_base_o;
  logic             first_d_o, last_d_o;
  logic [31:0]      tile_idx_o;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0]      stall_cnt_o, layer_cyc_o;
`endif

  tile_scheduler #(.CH_W(CH_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .layer_type_i(layer_type_i), .in_D_i(in_D_i), .out_K_i(out_K_i),
    .tile_D_i(tile_D_i), .tile_K_i(tile_K_i), .out_R_i(out_R_i), .tile_n_i(tile_n_i),
    .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .row_base_o(row_base_o), .row_len_o(row_len_o), .k_base_o(k_base_o),
    .d_base_o(d_base_o), .k_len_o(k_len_o), .d_len_o(d_len_o),
    .first_d_o(first_d_o), .last_d_o(last_d_o),
`ifdef TILE_SCHED_PERF_EN
    .stall_cnt_o(stall_cnt_o), .layer_cyc_o(layer_cyc_o),
`endif
    .tile_idx_o(tile_idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row_base, row_len, k_base, k_len, d_base, d_len, idx;
    bit first_d, last_d;
  } tile_t;

  tile_t exp_q[$];
  int total = 0, bad = 0;
  int cyc = 0;
  int acc_cnt = 0, first_acc_cyc = 0, last_acc_cyc = 0;
  int done_seen = 0, done_cyc = 0, stall_seen = 0;
  bit stalled_prev = 1'b0;
  logic [87:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [87:0] fields();
    return {row_base_o, row_len_o, k_base_o, d_base_o, k_len_o, d_len_o,
            first_d_o, last_d_o, tile_idx_o};
  endfunction

  // Monitor: stability while stalled, scoreboard pop on accept, done capture.
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (tile_valid_o && stalled_prev) begin
        total++;
        if (fields() !== held) begin
          bad++;
          $display("FAIL stable: got %h expected %h", fields(), held);
        end
      end
      stalled_prev = tile_valid_o && !tile_ready_i;
      held = fields();
      if (stalled_prev) stall_seen++;
      if (tile_valid_o && tile_ready_i) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_tile: got tile_idx %0d expected no tile", tile_idx_o);
        end else begin
          tile_t e;
          e = exp_q.pop_front();
          check("tile_idx", int'(tile_idx_o), e.idx);
          check("row_base", int'(row_base_o), e.row_base);
          check("row_len",  int'(row_len_o),  e.row_len);
          check("k_base",   int'(k_base_o),   e.k_base);
          check("k_len",    int'(k_len_o),    e.k_len);
          check("d_base",   int'(d_base_o),   e.d_base);
          check("d_len",    int'(d_len_o),    e.d_len);
          check("first_d",  int'(first_d_o),  int'(e.first_d));
          check("last_d",   int'(last_d_o),   int'(e.last_d));
        end
        acc_cnt++;
        if (acc_cnt == 1) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
      end
      if (done_o) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  // Reference loop nest producing the expected tile sequence of one layer.
  task automatic push_model(input int lt, input int ind, input int outk, input int td,
                            input int tk, input int outr, input int tn);
    int rpt, tde, tke, idx, rl, kl, dl;
    rpt = (tn == 0) ? 1 : ((tn > outr) ? outr : tn);
    tde = (td == 0) ? 1 : td;
    tke = (tk == 0) ? 1 : tk;
    idx = 0;
    if (ind == 0 || outk == 0 || outr == 0) return;
    for (int r = 0; r < outr; r += rpt) begin
      rl = (rpt < outr - r) ? rpt : outr - r;
      for (int k = 0; k < outk; k += tke) begin
        kl = (tke < outk - k) ? tke : outk - k;
        if (lt == 1) begin
          exp_q.push_back('{row_base: r, row_len: rl, k_base: k, k_len: kl,
                            d_base: k, d_len: kl, idx: idx, first_d: 1'b1, last_d: 1'b1});
          idx++;
        end else begin
          for (int d = 0; d < ind; d += tde) begin
            dl = (tde < ind - d) ? tde : ind - d;
            exp_q.push_back('{row_base: r, row_len: rl, k_base: k, k_len: kl,
                              d_base: d, d_len: dl, idx: idx,
                              first_d: (d == 0), last_d: (d + dl == ind)});
            idx++;
          end
        end
      end
    end
  endtask

  task automatic drive_cfg(input int lt, input int ind, input int outk, input int td,
                           input int tk, input int outr, input int tn);
    layer_type_i = 2'(lt);
    in_D_i       = CH_W'(ind);
    out_K_i      = CH_W'(outk);
    tile_D_i     = DIM_W'(td);
    tile_K_i     = DIM_W'(tk);
    out_R_i      = DIM_W'(outr);
    tile_n_i     = 32'(tn);
  endtask

  task automatic run_layer(input string name, input int lt, input int ind, input int outk,
                           input int td, input int tk, input int outr, input int tn,
                           input bit rand_ready, input int exp_tiles);
    int start_cyc;
    push_model(lt, ind, outk, td, tk, outr, tn);
    acc_cnt = 0; done_seen = 0; stall_seen = 0;
    @(posedge clk); #1;
    drive_cfg(lt, ind, outk, td, tk, outr, tn);
    tile_ready_i = 1'b1;
    start_i = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (done_seen != 0) break;
      if (rand_ready) begin
        tile_ready_i = 1'($urandom_range(0, 1));
        // a start while busy must be ignored, even with different config
        if (i == 3) begin
          start_i = 1'b1;
          in_D_i  = CH_W'(5);
        end
      end
    end
    if (done_seen == 0) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done_o expected done_o", name);
    end
    tile_ready_i = 1'b1;
    check({name, "_tiles"}, acc_cnt, exp_tiles);
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_done_cnt"}, done_seen, 1);
    if (exp_tiles > 0) check({name, "_done_lat"}, done_cyc, last_acc_cyc + 1);
    else               check({name, "_done_lat"}, done_cyc - start_cyc, 2);
    if (!rand_ready && exp_tiles > 0)
      check({name, "_back2back"}, last_acc_cyc - first_acc_cyc, exp_tiles - 1);
    check({name, "_busy_after"}, int'(busy_o), 0);
    check({name, "_done_after"}, int'(done_o), 0);
`ifdef TILE_SCHED_PERF_EN
    check({name, "_stall_cnt"}, int'(stall_cnt_o), stall_seen);
    check({name, "_layer_cyc"}, int'(layer_cyc_o), done_cyc - start_cyc);
`endif
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, int'(tile_valid_o), 0);
    check({name, "_busy"},  int'(busy_o), 0);
    check({name, "_done"},  int'(done_o), 0);
    check({name, "_idx"},   int'(tile_idx_o), 0);
    check({name, "_fields"}, (fields() == '0) ? 1 : 0, 1);
`ifdef TILE_SCHED_PERF_EN
    check({name, "_stall"}, int'(stall_cnt_o), 0);
    check({name, "_cyc"},   int'(layer_cyc_o), 0);
`endif
  endtask

  initial begin
    int seen_valid;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("reset");

    run_layer("pw",      0, 64, 64, 32, 32, 4, 2,   1'b0, 8);
    run_layer("std_d",   2, 25, 4,  10, 4,  1, 1,   1'b0, 3);
    run_layer("dw",      1, 25, 25, 7,  10, 3, 0,   1'b0, 9);
    run_layer("stall",   0, 64, 64, 32, 32, 4, 2,   1'b1, 8);
    run_layer("zero_d",  0, 0,  64, 32, 32, 4, 2,   1'b0, 0);
    run_layer("clamp",   2, 5,  3,  0,  0,  3, 100, 1'b0, 15);

    // reset while the third tile is pending
    push_model(0, 64, 64, 32, 32, 4, 2);
    acc_cnt = 0;
    @(posedge clk); #1;
    drive_cfg(0, 64, 64, 32, 32, 4, 2);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tile_valid_o && tile_idx_o == 32'd2) break;
      @(posedge clk); #1;
    end
    check("rst_reach_tile2", int'(tile_idx_o), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("rst_mid");
    rst = 1'b0;
    check("rst_accepted", acc_cnt, 2);
    exp_q.delete();
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (tile_valid_o) seen_valid++;
    end
    check("rst_no_valid", seen_valid, 0);

    run_layer("pw_again", 0, 64, 64, 32, 32, 4, 2, 1'b0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
